// File: rtl/data_mover_bram_ncore.sv
// Streams words from a source BRAM, splits each word into NUM_CORE operand lanes (a*b or a+b)
// and writes packed lane results to a destination BRAM. Define DATA_MOVER_ACC_EN for per-lane accumulation.
module data_mover_bram_ncore #(
  parameter int CNT_BIT       = 31,
  parameter int AWIDTH        = 12,
  parameter int MEM_SIZE      = 4096,
  parameter int IN_DATA_WIDTH = 8,
  parameter int NUM_CORE      = 2,
  parameter int DWIDTH        = NUM_CORE * 2 * IN_DATA_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_run,
  input  logic [CNT_BIT-1:0] i_num_cnt,
  input  logic               i_mode,
  input  logic [AWIDTH-1:0]  i_src_base,
  input  logic [AWIDTH-1:0]  i_dst_base,
  output logic               o_idle,
  output logic               o_read,
  output logic               o_write,
  output logic               o_done,
  output logic [AWIDTH-1:0]  addr_b0,
  output logic               ce_b0,
  output logic               we_b0,
  input  logic [DWIDTH-1:0]  q_b0,
  output logic [DWIDTH-1:0]  d_b0,
  output logic [AWIDTH-1:0]  addr_b1,
  output logic               ce_b1,
  output logic               we_b1,
  input  logic [DWIDTH-1:0]  q_b1,
  output logic [DWIDTH-1:0]  d_b1
);

  localparam int W = IN_DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_BIT-1:0]  r_cnt;
  logic [CNT_BIT-1:0]  r_rd_cnt;
  logic [CNT_BIT-1:0]  r_wr_cnt;
  logic                r_mode;
  logic [AWIDTH-1:0]   r_src_base;
  logic [AWIDTH-1:0]   r_dst_base;
  logic                r_rd_vld;
  logic                r_we;
  logic [AWIDTH-1:0]   r_wr_addr;
  logic [DWIDTH-1:0]   r_wr_data;
  logic                w_start;
  logic                w_rd_en;
  logic                w_last_wr;
  logic [DWIDTH-1:0]   w_result;
  logic                w_unused;

  assign w_start   = (r_state == S_IDLE) && i_run;
  assign w_rd_en   = (r_state == S_RUN) && (r_rd_cnt < r_cnt);
  // r_wr_cnt is bumped on the edge that raises r_we, so it equals r_cnt during the final write
  assign w_last_wr = r_we && (r_wr_cnt == r_cnt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_run) w_next = (i_num_cnt == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_last_wr) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_mode     <= 1'b0;
      r_src_base <= '0;
      r_dst_base <= '0;
      r_rd_vld   <= 1'b0;
      r_we       <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_rd_vld <= w_rd_en;
      r_we     <= r_rd_vld;
      if (w_start) begin
        r_cnt      <= i_num_cnt;
        r_mode     <= i_mode;
        r_src_base <= i_src_base;
        r_dst_base <= i_dst_base;
        r_rd_cnt   <= '0;
        r_wr_cnt   <= '0;
      end else begin
        if (w_rd_en) r_rd_cnt <= r_rd_cnt + CNT_BIT'(1);
        if (r_rd_vld) begin
          r_wr_data <= w_result;
          r_wr_addr <= r_dst_base + r_wr_cnt[AWIDTH-1:0];
          r_wr_cnt  <= r_wr_cnt + CNT_BIT'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CORE; g++) begin : g_lane
    logic [W-1:0]   w_a;
    logic [W-1:0]   w_b;
    logic [2*W-1:0] w_op;
    logic [2*W-1:0] w_res;

    assign w_a  = q_b0[DWIDTH-1-2*W*g -: W];
    assign w_b  = q_b0[DWIDTH-1-W-2*W*g -: W];
    assign w_op = r_mode ? ({{W{1'b0}}, w_a} + {{W{1'b0}}, w_b})
                         : ({{W{1'b0}}, w_a} * {{W{1'b0}}, w_b});

`ifdef DATA_MOVER_ACC_EN
    logic [2*W-1:0] r_acc;

    assign w_res = r_acc + w_op;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      r_acc <= '0;
      else if (w_start)  r_acc <= '0;
      else if (r_rd_vld) r_acc <= w_res;
    end
`else
    assign w_res = w_op;
`endif

    assign w_result[DWIDTH-1-2*W*g -: 2*W] = w_res;
  end

  assign o_idle  = (r_state == S_IDLE);
  assign o_done  = (r_state == S_DONE);
  assign ce_b0   = w_rd_en;
  assign o_read  = w_rd_en;
  assign addr_b0 = w_rd_en ? (r_src_base + r_rd_cnt[AWIDTH-1:0]) : '0;
  assign we_b0   = 1'b0;
  assign d_b0    = '0;
  assign ce_b1   = r_we;
  assign we_b1   = r_we;
  assign o_write = r_we;
  assign addr_b1 = r_wr_addr;
  assign d_b1    = r_wr_data;

  assign w_unused = (^q_b1) ^ (MEM_SIZE == 0);

endmodule

// File: tb/tb_data_mover_bram_ncore.sv
// Scoreboard bench for data_mover_bram_ncore: stimulus pushes expected reads/writes, a monitor pops them.
// Expectations follow DATA_MOVER_ACC_EN when the bench is built with that macro.
module tb_data_mover_bram_ncore;

`ifdef DATA_MOVER_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_run;
  logic [30:0] i_num_cnt;
  logic        i_mode;
  logic [11:0] i_src_base;
  logic [11:0] i_dst_base;
  logic        o_idle, o_read, o_write, o_done;
  logic [11:0] addr_b0, addr_b1;
  logic        ce_b0, we_b0, ce_b1, we_b1;
  logic [31:0] q_b0, d_b0, q_b1, d_b1;

  logic [31:0] srcMem [0:4095];
  logic [31:0] dstMem [0:4095];
  logic [11:0] rdQ [$];
  wr_t         wrQ [$];
  int          assertions = 0;
  int          failures = 0;

  data_mover_bram_ncore dut (
    .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_num_cnt(i_num_cnt), .i_mode(i_mode),
    .i_src_base(i_src_base), .i_dst_base(i_dst_base), .o_idle(o_idle), .o_read(o_read),
    .o_write(o_write), .o_done(o_done), .addr_b0(addr_b0), .ce_b0(ce_b0), .we_b0(we_b0),
    .q_b0(q_b0), .d_b0(d_b0), .addr_b1(addr_b1), .ce_b1(ce_b1), .we_b1(we_b1),
    .q_b1(q_b1), .d_b1(d_b1)
  );

  always #5 clk = ~clk;

  assign q_b1 = 32'h0;

  // Two single-port BRAM models: the source reads with one cycle of latency, the destination captures writes
  always @(posedge clk) begin
    if (ce_b0) q_b0 <= srcMem[addr_b0];
    if (ce_b1 && we_b1) dstMem[addr_b1] = d_b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] laneOp(input logic [31:0] w, input bit mode);
    logic [15:0] r0, r1;
    r0 = mode ? 16'(w[31:24]) + 16'(w[23:16]) : 16'(w[31:24]) * 16'(w[23:16]);
    r1 = mode ? 16'(w[15:8]) + 16'(w[7:0]) : 16'(w[15:8]) * 16'(w[7:0]);
    return {r0, r1};
  endfunction

  function automatic logic [31:0] laneAdd(input logic [31:0] x, input logic [31:0] y);
    return {x[31:16] + y[31:16], x[15:0] + y[15:0]};
  endfunction

  task automatic pushReads(input logic [11:0] src, input int cnt);
    for (int k = 0; k < cnt; k++) rdQ.push_back(src + 12'(k));
  endtask

  task automatic pushWrite(input logic [11:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    wrQ.push_back(e);
  endtask

  // Monitor: every read issue and every write strobe is matched against the head of its queue
  always @(negedge clk) begin
    if (reset_n) begin
      if (ce_b0) begin
        if (rdQ.size() == 0) checkOutput("unexpected_read_ce", 32'(ce_b0), 32'd0);
        else checkOutput("read_addr", 32'(addr_b0), 32'(rdQ.pop_front()));
      end
      if (we_b1) begin
        if (wrQ.size() == 0) checkOutput("unexpected_write_we", 32'(we_b1), 32'd0);
        else begin
          wr_t e;
          e = wrQ.pop_front();
          checkOutput("write_addr", 32'(addr_b1), 32'(e.addr));
          checkOutput("write_data", d_b1, e.data);
          checkOutput("write_ce", 32'(ce_b1), 32'd1);
        end
      end
    end
  end

  // Starts one run and checks done/idle timing relative to the start edge
  task automatic applyStimulus(input int cnt, input bit mode, input logic [11:0] src,
                               input logic [11:0] dst, input bit midPulse);
    int c;
    @(negedge clk);
    i_num_cnt  = 31'(cnt);
    i_mode     = mode;
    i_src_base = src;
    i_dst_base = dst;
    i_run      = 1'b1;
    @(negedge clk);
    i_run = 1'b0;
    c = 1;
    if (cnt > 0) checkOutput("idle_low_cycle1", 32'(o_idle), 32'd0);
    while (!o_done && c < cnt + 20) begin
      @(negedge clk);
      c++;
      if (midPulse) i_run = (c == 2);
    end
    i_run = 1'b0;
    checkOutput("done_cycle", 32'(c), (cnt == 0) ? 32'd1 : 32'(cnt + 3));
    @(negedge clk);
    checkOutput("done_single_pulse", 32'(o_done), 32'd0);
    checkOutput("idle_after_done", 32'(o_idle), 32'd1);
    checkOutput("read_queue_drained", 32'(rdQ.size()), 32'd0);
    checkOutput("write_queue_drained", 32'(wrQ.size()), 32'd0);
  endtask

  task automatic resetMidRun();
    for (int k = 0; k < 8; k++) begin
      srcMem[12'h20 + 12'(k)] = 32'h0302_0405;
      dstMem[12'h100 + 12'(k)] = 32'hDEAD_BEEF;
    end
    pushReads(12'h20, 8);
    pushWrite(12'h100, 32'h0006_0014);
    pushWrite(12'h101, ACC ? 32'h000C_0028 : 32'h0006_0014);
    @(negedge clk);
    i_num_cnt  = 31'd8;
    i_mode     = 1'b0;
    i_src_base = 12'h20;
    i_dst_base = 12'h100;
    i_run      = 1'b1;
    @(negedge clk);
    i_run = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_we_b1", 32'(we_b1), 32'd0);
    checkOutput("rst_mid_ce_b0", 32'(ce_b0), 32'd0);
    checkOutput("rst_mid_idle", 32'(o_idle), 32'd1);
    checkOutput("rst_mid_write", 32'(o_write), 32'd0);
    checkOutput("rst_mid_addr_b1", 32'(addr_b1), 32'd0);
    checkOutput("rst_mid_d_b1", d_b1, 32'd0);
    checkOutput("rst_mid_writes_seen", 32'(wrQ.size()), 32'd0);
    rdQ.delete();
    wrQ.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("rst_mid_word0_kept", dstMem[12'h100], 32'h0006_0014);
    checkOutput("rst_mid_word1_untouched", dstMem[12'h101], 32'hDEAD_BEEF);
    checkOutput("rst_mid_word7_untouched", dstMem[12'h107], 32'hDEAD_BEEF);
    checkOutput("rst_mid_idle_after", 32'(o_idle), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] acc;
    logic [31:0] op;
    reset_n    = 1'b0;
    i_run      = 1'b0;
    i_num_cnt  = '0;
    i_mode     = 1'b0;
    i_src_base = '0;
    i_dst_base = '0;
    for (int k = 0; k < 4096; k++) dstMem[k] = 32'h0;
    #1;
    checkOutput("reset_idle", 32'(o_idle), 32'd1);
    checkOutput("reset_done", 32'(o_done), 32'd0);
    checkOutput("reset_read", 32'(o_read), 32'd0);
    checkOutput("reset_write", 32'(o_write), 32'd0);
    checkOutput("reset_ce_b0", 32'(ce_b0), 32'd0);
    checkOutput("reset_we_b1", 32'(we_b1), 32'd0);
    checkOutput("reset_addr_b0", 32'(addr_b0), 32'd0);
    checkOutput("reset_addr_b1", 32'(addr_b1), 32'd0);
    checkOutput("reset_d_b1", d_b1, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] full-memory product run, 4096 random words");
    acc = 32'h0;
    for (int k = 0; k < 4096; k++) begin
      srcMem[k] = $urandom;
      op = laneOp(srcMem[k], 1'b0);
      acc = ACC ? laneAdd(acc, op) : op;
      pushWrite(12'(k), acc);
    end
    pushReads(12'h000, 4096);
    applyStimulus(4096, 1'b0, 12'h000, 12'h000, 1'b0);

    $display("[TB] directed single word, product and sum");
    srcMem[12'h010] = 32'hFFFF_FF02;
    pushReads(12'h010, 1);
    pushWrite(12'h200, 32'hFE01_01FE);
    applyStimulus(1, 1'b0, 12'h010, 12'h200, 1'b0);
    pushReads(12'h010, 1);
    pushWrite(12'h201, 32'h01FE_0101);
    applyStimulus(1, 1'b1, 12'h010, 12'h201, 1'b0);
    checkOutput("dst_product_word", dstMem[12'h200], 32'hFE01_01FE);
    checkOutput("dst_sum_word", dstMem[12'h201], 32'h01FE_0101);

    $display("[TB] zero count");
    applyStimulus(0, 1'b0, 12'h010, 12'h202, 1'b0);

    $display("[TB] address wrap with ignored mid-run start");
    srcMem[12'hFFE] = 32'h0203_0405;
    srcMem[12'hFFF] = 32'h0A0B_0C0D;
    srcMem[12'h000] = 32'h1010_0101;
    pushReads(12'hFFE, 3);
    pushWrite(12'hFFF, 32'h0006_0014);
    pushWrite(12'h000, ACC ? 32'h0074_00B0 : 32'h006E_009C);
    pushWrite(12'h001, ACC ? 32'h0174_00B1 : 32'h0100_0001);
    applyStimulus(3, 1'b0, 12'hFFE, 12'hFFF, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("no_restart_after_pulse", 32'(o_idle), 32'd1);

    $display("[TB] all-ones operands over three words");
    for (int k = 0; k < 3; k++) srcMem[12'h40 + 12'(k)] = 32'h0101_0101;
    pushReads(12'h040, 3);
    pushWrite(12'h300, 32'h0001_0001);
    pushWrite(12'h301, ACC ? 32'h0002_0002 : 32'h0001_0001);
    pushWrite(12'h302, ACC ? 32'h0003_0003 : 32'h0001_0001);
    applyStimulus(3, 1'b0, 12'h040, 12'h300, 1'b0);

    $display("[TB] reset asserted mid-run");
    resetMidRun();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/data_mover_bram_ncore.md
# data_mover_bram_ncore

Parametrised successor of the two-lane BRAM data mover. Streams `i_num_cnt` words from a source true-dual-port BRAM (port A) and unpacks each word into `NUM_CORE` lanes of operand pairs (a, b). Each lane computes a product or a sum, and the packed results are written to a destination BRAM (port A) at one word per clock. Source and destination base addresses are programmable, and an optional per-lane accumulate mode is available. Sits between the preloading BRAM and the result BRAM in the multi-core datapath.

## Interface
- `CNT_BIT`, 31, width of the word counter.
- `AWIDTH`, 12, BRAM address width.
- `MEM_SIZE`, 4096, BRAM depth in words.
- `IN_DATA_WIDTH`, 8, operand width W.
- `NUM_CORE`, 2, lane count N.
- `DWIDTH`, N\*2\*W (32), BRAM word width for both source and destination.

Ports:
- `clk` in 1: the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `i_run` in 1: start pulse; sampled only in IDLE.
- `i_num_cnt` in CNT_BIT: number of words to process.
- `i_mode` in 1: 0 = a\*b, 1 = a+b (zero-extended to 2W). Latched at start.
- `i_src_base` / `i_dst_base` in AWIDTH each: start addresses. Latched at start.
- `o_idle` in 1 (out): high in IDLE.
- `o_read` out 1: high while read issue is active.
- `o_write` out 1: high while write is active.
- `o_done` out 1: one-cycle pulse.
- `addr_b0` out AWIDTH, `ce_b0` out 1, `we_b0` out 1 (always 0), `q_b0` in DWIDTH, `d_b0` out DWIDTH (always 0).
- `addr_b1` out AWIDTH, `ce_b1` out 1, `we_b1` out 1, `q_b1` in DWIDTH (unused), `d_b1` out DWIDTH.

## Operation
- FSM states:
  - IDLE → RUN on `i_run` (with `i_num_cnt` > 0).
  - IDLE → DONE on `i_run` with `i_num_cnt` == 0; no memory access occurs.
  - RUN → DONE when the last write retires.
  - DONE → IDLE unconditionally.
- `i_run` outside IDLE is ignored. Inputs are latched on the start edge.
- Read side: a read counter k runs 0..cnt-1.
  - `ce_b0` = 1 and `addr_b0` = src_base + k for each k in RUN.
  - `o_read` mirrors `ce_b0`.
- Word packing, with lane 0 in the MSBs:
  - Source word = {a_0, b_0, …, a_{N-1}, b_{N-1}}.
  - Result word = {r_0, …, r_{N-1}}, each r_i 2W bits wide.
- Arithmetic is unsigned.
  - The product a\*b fits exactly in 2W bits.
  - The sum a+b is zero-extended to 2W bits.
- Write side: word k is written to `addr_b1` = dst_base + k with `ce_b1` = `we_b1` = 1. `o_write` mirrors `we_b1`.
- Addresses wrap modulo 2^AWIDTH. Counts larger than MEM_SIZE therefore overwrite from the base.
- There is no backpressure; throughput is one word per cycle.

## Timing
- Reset values: FSM = IDLE, `o_idle` = 1, and every other output and internal register = 0.
- The source BRAM read latency is 1 cycle.
- Pipeline: read issued in cycle t, `q_b0` valid in t+1, result registered at the end of t+1, write in t+2.
- With `i_run` sampled at edge 0:
  - RUN begins in cycle 1, and the first read is issued in cycle 1.
  - Writes occur in cycles 3..N+2, where N is the word count.
  - `o_done` is high in cycle N+3.
  - `o_idle` is high again in cycle N+4.
- `o_idle` is low from cycle 1 until it returns high in cycle N+4.
- Zero count: `o_done` is high in cycle 1 and `o_idle` is high in cycle 2.
- Reset asserted mid-operation:
  - All state clears immediately and `we_b1` drops asynchronously.
  - No further reads or writes occur. Partially written destination contents are left as-is.

## Configuration
- `DATA_MOVER_ACC_EN` defined:
  - Each lane keeps a 2W-bit accumulator, cleared on start.
  - r_i = acc_i + op(a_i, b_i) modulo 2^(2W), and acc_i is updated to r_i. Every word writes the running prefix result.
- Not defined: r_i = op(a_i, b_i), and no accumulator registers exist.

## Test plan
- Reset, then start with cnt=4096, mode=0, bases=0, source random → destination[k] lane i = a_i\*b_i. `o_done` pulses once, 4099 cycles after the start edge.
- Source word 0xFFFF_FF02 with mode=0, cnt=1 → destination = 0xFE01_01FE.
  - Lane 0: 255\*255.
  - Lane 1: 255\*2.
- Same word with mode=1 → destination = 0x01FE_0101.
- cnt=0 → `o_done` in cycle 1, no `ce_b0`/`ce_b1` activity, `o_idle` high in cycle 2.
- src_base=0xFFE, dst_base=0xFFF, cnt=3 → reads at 0xFFE, 0xFFF, 0x000 and writes at 0xFFF, 0x000, 0x001.
  - Also pulse `i_run` mid-run → it is ignored.
- With `DATA_MOVER_ACC_EN` defined: three words each with all operands = 1, mode=0 → lane results 1, 2, 3.
  - Then assert `reset_n` low mid-run → outputs return to reset values within the same cycle, and no later writes occur.
